// File: rtl/knn_sorted_list_pkg.sv
`default_nettype none
// ============================================================================
// Module      : knn_sorted_list_pkg
// Description : Shared definitions for the KNN sorted neighbour list:
//               default widths/depth, FSM state encodings and a width helper.
// Revision    : 1.0 - initial release
// ============================================================================
package knn_sorted_list_pkg;

  localparam int KNN_DEF_DATA_W  = 32;
  localparam int KNN_DEF_LABEL_W = 8;
  localparam int KNN_DEF_K       = 10;

  // FSM encoding (VOTE is only reachable when KNN_VOTE_EN is defined)
  localparam int              ST_W      = 2;
  localparam logic [ST_W-1:0] ST_ACCEPT = 2'd0;
  localparam logic [ST_W-1:0] ST_VOTE   = 2'd1;
  localparam logic [ST_W-1:0] ST_DONE   = 2'd2;

  // Read index width; never narrower than one bit so K = 1 still has a port.
  function automatic int knn_idx_w(input int k);
    return (k > 1) ? $clog2(k) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/knn_list_cell.sv
`default_nettype none
// ============================================================================
// Module      : knn_list_cell
// Description : One entry of the insertion-sorted neighbour list. Holds a
//               distance, a label and an occupancy bit. On shift it copies
//               its upstream neighbour; on load it captures the candidate.
//               o_wants flags that this entry would accept the candidate
//               (empty, or candidate strictly nearer than what is stored).
// Ports       : clk, rst          - clock, synchronous active-high reset
//               i_clear           - empty this entry
//               i_cand_dist/label - incoming candidate
//               i_prev_*          - contents of the cell one position nearer
//               i_shift_en        - take i_prev_* (insertion point is above)
//               i_load_en         - take the candidate (this is the insertion point)
//               o_dist/label/occ  - stored contents
//               o_wants           - compare flag used by the priority logic
// Revision    : 1.0 - initial release
// ============================================================================
module knn_list_cell
  import knn_sorted_list_pkg::*;
#(
  parameter int DATA_W  = KNN_DEF_DATA_W,
  parameter int LABEL_W = KNN_DEF_LABEL_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_clear,
  input  logic [DATA_W-1:0]  i_cand_dist,
  input  logic [LABEL_W-1:0] i_cand_label,
  input  logic [DATA_W-1:0]  i_prev_dist,
  input  logic [LABEL_W-1:0] i_prev_label,
  input  logic               i_prev_occ,
  input  logic               i_shift_en,
  input  logic               i_load_en,
  output logic [DATA_W-1:0]  o_dist,
  output logic [LABEL_W-1:0] o_label,
  output logic               o_occ,
  output logic               o_wants
);

  logic [DATA_W-1:0]  r_dist;
  logic [LABEL_W-1:0] r_label;
  logic               r_occ;

  always_ff @(posedge clk) begin
    if (rst || i_clear) begin
      r_dist  <= '0;
      r_label <= '0;
      r_occ   <= 1'b0;
    end else if (i_shift_en) begin
      r_dist  <= i_prev_dist;
      r_label <= i_prev_label;
      r_occ   <= i_prev_occ;
    end else if (i_load_en) begin
      r_dist  <= i_cand_dist;
      r_label <= i_cand_label;
      r_occ   <= 1'b1;
    end
  end

  // Strict compare: an equal distance does not displace an earlier arrival.
  assign o_wants = ~r_occ | (i_cand_dist < r_dist);

  assign o_dist  = r_dist;
  assign o_label = r_label;
  assign o_occ   = r_occ;

endmodule
`default_nettype wire

// File: rtl/knn_sorted_list.sv
`default_nettype none
// ============================================================================
// Module      : knn_sorted_list
// Description : K-deep insertion-sorted neighbour list. Accepts one
//               (distance, label) candidate per cycle, keeps the K nearest in
//               ascending order and exposes them on a combinational indexed
//               read port once the final training point has been inserted.
//               Optional build macro KNN_VOTE_EN adds a K-cycle majority vote
//               over the stored labels (outputs vote_label / vote_cnt).
// Ports       : clk, rst              - clock, synchronous active-high reset
//               clear                 - start a new test point
//               in_valid/in_ready     - candidate handshake
//               in_dist/label/last    - candidate and final-point marker
//               done                  - list final, read port valid
//               count                 - occupied entries (saturates at K)
//               rd_idx                - read index, 0 = nearest
//               rd_dist/label/occ     - entry at rd_idx (zeros if empty/out of range)
//               vote_label/vote_cnt   - majority label and its count (KNN_VOTE_EN)
// Revision    : 1.0 - initial release
// ============================================================================
module knn_sorted_list
  import knn_sorted_list_pkg::*;
#(
  parameter  int DATA_W  = KNN_DEF_DATA_W,
  parameter  int LABEL_W = KNN_DEF_LABEL_W,
  parameter  int K       = KNN_DEF_K,
  localparam int IDX_W   = knn_idx_w(K),
  localparam int CNT_W   = $clog2(K + 1)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_dist,
  input  logic [LABEL_W-1:0] in_label,
  input  logic               in_last,
  output logic               done,
  output logic [CNT_W-1:0]   count,
  input  logic [IDX_W-1:0]   rd_idx,
  output logic [DATA_W-1:0]  rd_dist,
  output logic [LABEL_W-1:0] rd_label,
  output logic               rd_occ
`ifdef KNN_VOTE_EN
  ,
  output logic [LABEL_W-1:0] vote_label,
  output logic [CNT_W-1:0]   vote_cnt
`endif
);

  logic [ST_W-1:0]    r_state;
  logic [ST_W-1:0]    w_next_state;
  logic               w_hs;
  logic               w_insert;
  logic [K-1:0]       w_wants;
  logic [K-1:0]       w_below;   // some nearer cell already wants the candidate
  logic [K-1:0]       w_occ;
  logic [DATA_W-1:0]  w_dist  [K];
  logic [LABEL_W-1:0] w_label [K];
  logic [CNT_W-1:0]   r_count;

  // clear wins over a simultaneous handshake: the candidate is dropped.
  assign w_hs     = in_valid & in_ready & ~clear;
  assign w_insert = w_hs & (|w_wants);

  // Prefix OR of the want flags; the lowest wanting cell is the insertion
  // point, every cell after it shifts down by one.
  always_comb begin : p_prefix
    logic v_acc;
    v_acc   = 1'b0;
    w_below = '0;
    for (int i = 0; i < K; i++) begin
      w_below[i] = v_acc;
      v_acc      = v_acc | w_wants[i];
    end
  end

  for (genvar gi = 0; gi < K; gi++) begin : g_cell
    logic [DATA_W-1:0]  w_prev_dist;
    logic [LABEL_W-1:0] w_prev_label;
    logic               w_prev_occ;

    if (gi == 0) begin : g_head
      assign w_prev_dist  = '0;
      assign w_prev_label = '0;
      assign w_prev_occ   = 1'b0;
    end else begin : g_link
      assign w_prev_dist  = w_dist[gi-1];
      assign w_prev_label = w_label[gi-1];
      assign w_prev_occ   = w_occ[gi-1];
    end

    knn_list_cell #(
      .DATA_W  (DATA_W),
      .LABEL_W (LABEL_W)
    ) u_cell (
      .clk          (clk),
      .rst          (rst),
      .i_clear      (clear),
      .i_cand_dist  (in_dist),
      .i_cand_label (in_label),
      .i_prev_dist  (w_prev_dist),
      .i_prev_label (w_prev_label),
      .i_prev_occ   (w_prev_occ),
      .i_shift_en   (w_hs & w_below[gi]),
      .i_load_en    (w_hs & w_wants[gi] & ~w_below[gi]),
      .o_dist       (w_dist[gi]),
      .o_label      (w_label[gi]),
      .o_occ        (w_occ[gi]),
      .o_wants      (w_wants[gi])
    );
  end

  // Occupancy count, saturating at K (a full list keeps exactly K entries).
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_count <= '0;
    end else if (w_insert && (r_count < CNT_W'(K))) begin
      r_count <= r_count + CNT_W'(1);
    end
  end

  assign count = r_count;

`ifdef KNN_VOTE_EN
  logic [IDX_W-1:0]   r_vote_idx;
  logic [LABEL_W-1:0] r_best_label;
  logic [CNT_W-1:0]   r_best_cnt;
  logic [LABEL_W-1:0] w_cur_label;
  logic               w_cur_occ;
  logic [CNT_W-1:0]   w_match_cnt;

  // Entry under evaluation this vote cycle and how many occupied entries
  // share its label (itself included).
  always_comb begin
    w_cur_label = '0;
    w_cur_occ   = 1'b0;
    for (int i = 0; i < K; i++) begin
      if (r_vote_idx == IDX_W'(i)) begin
        w_cur_label = w_label[i];
        w_cur_occ   = w_occ[i];
      end
    end
    w_match_cnt = '0;
    for (int j = 0; j < K; j++) begin
      if (w_occ[j] && (w_label[j] == w_cur_label)) begin
        w_match_cnt = w_match_cnt + CNT_W'(1);
      end
    end
  end

  // Strictly-greater replacement keeps the nearer entry on a tied count.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      r_vote_idx   <= '0;
      r_best_label <= '0;
      r_best_cnt   <= '0;
    end else if ((r_state == ST_ACCEPT) && w_hs && in_last) begin
      r_vote_idx   <= '0;
      r_best_label <= '0;
      r_best_cnt   <= '0;
    end else if (r_state == ST_VOTE) begin
      if (w_cur_occ && (w_match_cnt > r_best_cnt)) begin
        r_best_label <= w_cur_label;
        r_best_cnt   <= w_match_cnt;
      end
      r_vote_idx <= r_vote_idx + IDX_W'(1);
    end
  end

  assign vote_label = r_best_label;
  assign vote_cnt   = r_best_cnt;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_ACCEPT;
    end else begin
      r_state <= w_next_state;
    end
  end

  // FSM: next state
  always_comb begin
    w_next_state = r_state;
    if (clear) begin
      w_next_state = ST_ACCEPT;
    end else begin
      case (r_state)
        ST_ACCEPT: begin
          if (w_hs && in_last) begin
`ifdef KNN_VOTE_EN
            w_next_state = ST_VOTE;
`else
            w_next_state = ST_DONE;
`endif
          end
        end
`ifdef KNN_VOTE_EN
        ST_VOTE: begin
          if (r_vote_idx == IDX_W'(K - 1)) begin
            w_next_state = ST_DONE;
          end
        end
`endif
        ST_DONE: begin
          w_next_state = ST_DONE;
        end
        default: begin
          w_next_state = ST_ACCEPT;
        end
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    in_ready = (r_state == ST_ACCEPT);
    done     = (r_state == ST_DONE);
  end

  // Read port: out-of-range or unoccupied entries read as zero.
  always_comb begin
    rd_dist  = '0;
    rd_label = '0;
    rd_occ   = 1'b0;
    for (int i = 0; i < K; i++) begin
      if ((rd_idx == IDX_W'(i)) && w_occ[i]) begin
        rd_dist  = w_dist[i];
        rd_label = w_label[i];
        rd_occ   = 1'b1;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_knn_sorted_list.sv
`timescale 1ns/100ps
`default_nettype none
// ============================================================================
// Module      : tb_knn_sorted_list
// Description : Directed self-checking bench for knn_sorted_list with K = 4.
//               Covers reset, ordered fill, full-list reject/replace, ties,
//               partial lists, clear priority and mid-fill reset. With
//               KNN_VOTE_EN defined it also checks vote timing and result.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_knn_sorted_list;

  localparam int DATA_W  = 32;
  localparam int LABEL_W = 8;
  localparam int K       = 4;
  localparam int IDX_W   = 2;
  localparam int CNT_W   = 3;

  logic               clk = 1'b0;
  logic               rst;
  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic [DATA_W-1:0]  in_dist;
  logic [LABEL_W-1:0] in_label;
  logic               in_last;
  logic               done;
  logic [CNT_W-1:0]   count;
  logic [IDX_W-1:0]   rd_idx;
  logic [DATA_W-1:0]  rd_dist;
  logic [LABEL_W-1:0] rd_label;
  logic               rd_occ;
`ifdef KNN_VOTE_EN
  logic [LABEL_W-1:0] vote_label;
  logic [CNT_W-1:0]   vote_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  logic [DATA_W-1:0]  ed [K];
  logic [LABEL_W-1:0] el [K];
  logic               eo [K];

  always #10 clk = ~clk;

  knn_sorted_list #(
    .DATA_W  (DATA_W),
    .LABEL_W (LABEL_W),
    .K       (K)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .clear    (clear),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_dist  (in_dist),
    .in_label (in_label),
    .in_last  (in_last),
    .done     (done),
    .count    (count),
    .rd_idx   (rd_idx),
    .rd_dist  (rd_dist),
    .rd_label (rd_label),
    .rd_occ   (rd_occ)
`ifdef KNN_VOTE_EN
    ,
    .vote_label (vote_label),
    .vote_cnt   (vote_cnt)
`endif
  );

  // One candidate handshake; returns 1 ns after the capturing edge.
  task automatic send(input logic [DATA_W-1:0] d, input logic [LABEL_W-1:0] l,
                      input logic last);
    in_valid = 1'b1;
    in_dist  = d;
    in_label = l;
    in_last  = last;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    in_dist = '0; in_label = '0; rd_idx = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    n_vec++;
    if (count !== 3'd0 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_ctrl: got count=%0d done=%0b ready=%0b, want 0 0 1", count, done, in_ready);
    end
    @(negedge clk);
    for (int i = 0; i < K; i++) begin
      rd_idx = IDX_W'(i); #1;
      n_vec++;
      if (rd_occ !== 1'b0 || rd_dist !== '0 || rd_label !== '0) begin
        n_err++;
        $display("FAIL reset_idx%0d: got occ=%0b dist=%0d label=%0d, want 0 0 0", i, rd_occ, rd_dist, rd_label);
      end
    end
  endtask

  task automatic test_fill();
    do_clear();
    send(32'd50, 8'd1, 1'b0);
    send(32'd20, 8'd2, 1'b0);
    send(32'd80, 8'd3, 1'b0);
    n_vec++;
    if (done !== 1'b0) begin
      n_err++;
      $display("FAIL fill_done_early: got done=%0b, want 0", done);
    end
    send(32'd10, 8'd4, 1'b1);
    n_vec++;
    if (done !== 1'b1 || in_ready !== 1'b0 || count !== 3'd4) begin
      n_err++;
      $display("FAIL fill_ctrl: got done=%0b ready=%0b count=%0d, want 1 0 4", done, in_ready, count);
    end
    ed = '{32'd10, 32'd20, 32'd50, 32'd80};
    el = '{8'd4, 8'd2, 8'd1, 8'd3};
    eo = '{1'b1, 1'b1, 1'b1, 1'b1};
    @(negedge clk);
    for (int i = 0; i < K; i++) begin
      rd_idx = IDX_W'(i); #1;
      n_vec++;
      if (rd_occ !== eo[i] || rd_dist !== ed[i] || rd_label !== el[i]) begin
        n_err++;
        $display("FAIL fill_idx%0d: got occ=%0b dist=%0d label=%0d, want occ=%0b dist=%0d label=%0d",
                 i, rd_occ, rd_dist, rd_label, eo[i], ed[i], el[i]);
      end
    end
    // A candidate offered while done must be ignored.
    in_valid = 1'b1; in_dist = 32'd5; in_label = 8'd9;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rd_idx = '0; #1;
    n_vec++;
    if (count !== 3'd4 || rd_dist !== 32'd10 || rd_label !== 8'd4 || done !== 1'b1) begin
      n_err++;
      $display("FAIL done_ignore: got count=%0d dist=%0d label=%0d done=%0b, want 4 10 4 1",
               count, rd_dist, rd_label, done);
    end
  endtask

  task automatic test_full();
    do_clear();
    send(32'd80, 8'd3, 1'b0);
    send(32'd50, 8'd1, 1'b0);
    send(32'd20, 8'd2, 1'b0);
    send(32'd10, 8'd4, 1'b0);
    send(32'd90, 8'd9, 1'b0);
    ed = '{32'd10, 32'd20, 32'd50, 32'd80};
    el = '{8'd4, 8'd2, 8'd1, 8'd3};
    eo = '{1'b1, 1'b1, 1'b1, 1'b1};
    @(negedge clk);
    for (int i = 0; i < K; i++) begin
      rd_idx = IDX_W'(i); #1;
      n_vec++;
      if (rd_occ !== eo[i] || rd_dist !== ed[i] || rd_label !== el[i]) begin
        n_err++;
        $display("FAIL full_reject_idx%0d: got occ=%0b dist=%0d label=%0d, want occ=%0b dist=%0d label=%0d",
                 i, rd_occ, rd_dist, rd_label, eo[i], ed[i], el[i]);
      end
    end
    send(32'd15, 8'd5, 1'b0);
    n_vec++;
    if (count !== 3'd4 || done !== 1'b0) begin
      n_err++;
      $display("FAIL full_count: got count=%0d done=%0b, want 4 0", count, done);
    end
    ed = '{32'd10, 32'd15, 32'd20, 32'd50};
    el = '{8'd4, 8'd5, 8'd2, 8'd1};
    @(negedge clk);
    for (int i = 0; i < K; i++) begin
      rd_idx = IDX_W'(i); #1;
      n_vec++;
      if (rd_occ !== eo[i] || rd_dist !== ed[i] || rd_label !== el[i]) begin
        n_err++;
        $display("FAIL full_insert_idx%0d: got occ=%0b dist=%0d label=%0d, want occ=%0b dist=%0d label=%0d",
                 i, rd_occ, rd_dist, rd_label, eo[i], ed[i], el[i]);
      end
    end
  endtask

  task automatic test_ties();
    do_clear();
    send(32'd30, 8'd7, 1'b0);
    send(32'd30, 8'd9, 1'b0);
    send(32'd25, 8'd6, 1'b0);
    n_vec++;
    if (count !== 3'd3) begin
      n_err++;
      $display("FAIL ties_count: got count=%0d, want 3", count);
    end
    ed = '{32'd25, 32'd30, 32'd30, 32'd0};
    el = '{8'd6, 8'd7, 8'd9, 8'd0};
    eo = '{1'b1, 1'b1, 1'b1, 1'b0};
    @(negedge clk);
    for (int i = 0; i < K; i++) begin
      rd_idx = IDX_W'(i); #1;
      n_vec++;
      if (rd_occ !== eo[i] || rd_dist !== ed[i] || rd_label !== el[i]) begin
        n_err++;
        $display("FAIL ties_idx%0d: got occ=%0b dist=%0d label=%0d, want occ=%0b dist=%0d label=%0d",
                 i, rd_occ, rd_dist, rd_label, eo[i], ed[i], el[i]);
      end
    end
  endtask

  task automatic test_partial();
    do_clear();
    send(32'd40, 8'd1, 1'b0);
    send(32'd60, 8'd2, 1'b1);
    n_vec++;
    if (count !== 3'd2 || done !== 1'b1) begin
      n_err++;
      $display("FAIL partial_ctrl: got count=%0d done=%0b, want 2 1", count, done);
    end
    ed = '{32'd40, 32'd60, 32'd0, 32'd0};
    el = '{8'd1, 8'd2, 8'd0, 8'd0};
    eo = '{1'b1, 1'b1, 1'b0, 1'b0};
    @(negedge clk);
    for (int i = 0; i < K; i++) begin
      rd_idx = IDX_W'(i); #1;
      n_vec++;
      if (rd_occ !== eo[i] || rd_dist !== ed[i] || rd_label !== el[i]) begin
        n_err++;
        $display("FAIL partial_idx%0d: got occ=%0b dist=%0d label=%0d, want occ=%0b dist=%0d label=%0d",
                 i, rd_occ, rd_dist, rd_label, eo[i], ed[i], el[i]);
      end
    end
    // in_last on the very first candidate
    do_clear();
    send(32'd70, 8'd3, 1'b1);
    rd_idx = '0; #1;
    n_vec++;
    if (count !== 3'd1 || done !== 1'b1 || rd_dist !== 32'd70 || rd_label !== 8'd3 || rd_occ !== 1'b1) begin
      n_err++;
      $display("FAIL first_last: got count=%0d done=%0b dist=%0d label=%0d occ=%0b, want 1 1 70 3 1",
               count, done, rd_dist, rd_label, rd_occ);
    end
  endtask

  task automatic test_clear_priority();
    do_clear();
    n_vec++;
    if (done !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0) begin
      n_err++;
      $display("FAIL clear_from_done: got done=%0b ready=%0b count=%0d, want 0 1 0", done, in_ready, count);
    end
    send(32'd11, 8'd1, 1'b0);
    clear = 1'b1; in_valid = 1'b1; in_dist = 32'd5; in_label = 8'd2;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    rd_idx = '0; #1;
    n_vec++;
    if (count !== 3'd0 || rd_occ !== 1'b0 || rd_dist !== 32'd0 || rd_label !== 8'd0) begin
      n_err++;
      $display("FAIL clear_priority: got count=%0d occ=%0b dist=%0d label=%0d, want 0 0 0 0",
               count, rd_occ, rd_dist, rd_label);
    end
    send(32'd12, 8'd3, 1'b0);
    rd_idx = '0; #1;
    n_vec++;
    if (count !== 3'd1 || rd_dist !== 32'd12 || rd_label !== 8'd3) begin
      n_err++;
      $display("FAIL after_clear: got count=%0d dist=%0d label=%0d, want 1 12 3", count, rd_dist, rd_label);
    end
  endtask

  task automatic test_rst_mid();
    send(32'd33, 8'd1, 1'b0);
    send(32'd44, 8'd2, 1'b0);
    rst = 1'b1; in_valid = 1'b1; in_dist = 32'd1; in_label = 8'd5;
    @(posedge clk); #1;
    rst = 1'b0; in_valid = 1'b0;
    n_vec++;
    if (count !== 3'd0 || done !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL rst_mid_ctrl: got count=%0d done=%0b ready=%0b, want 0 0 1", count, done, in_ready);
    end
    @(negedge clk);
    for (int i = 0; i < K; i++) begin
      rd_idx = IDX_W'(i); #1;
      n_vec++;
      if (rd_occ !== 1'b0 || rd_dist !== '0 || rd_label !== '0) begin
        n_err++;
        $display("FAIL rst_mid_idx%0d: got occ=%0b dist=%0d label=%0d, want 0 0 0", i, rd_occ, rd_dist, rd_label);
      end
    end
  endtask

`ifdef KNN_VOTE_EN
  task automatic test_vote();
    do_clear();
    send(32'd10, 8'd3, 1'b0);
    send(32'd20, 8'd5, 1'b0);
    send(32'd30, 8'd3, 1'b0);
    send(32'd40, 8'd5, 1'b1);
    // K vote cycles follow the last handshake; done rises on the K-th edge.
    for (int c = 0; c < K; c++) begin
      n_vec++;
      if (done !== 1'b0) begin
        n_err++;
        $display("FAIL vote_early_done c%0d: got done=%0b, want 0", c, done);
      end
      @(posedge clk); #1;
    end
    n_vec++;
    if (done !== 1'b1 || vote_label !== 8'd3 || vote_cnt !== 3'd2) begin
      n_err++;
      $display("FAIL vote_result: got done=%0b label=%0d cnt=%0d, want 1 3 2", done, vote_label, vote_cnt);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_fill();
    test_full();
    test_ties();
    test_partial();
    test_clear_priority();
    test_rst_mid();
`ifdef KNN_VOTE_EN
    test_vote();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
